fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch / program-counter stage directly upstream of the control decoder.
- Holds the PC that addresses instruction ROM and applies Jump/BranchEn from the decoder, plus the ALU branch-taken flag.
- Sequences Start → run → Halt and reports Done to the testbench harness.
- Next-PC rules: sequential increment, PC-relative jump, absolute branch target from LUT.

Parameters:
- PC_W, 10, program counter / ROM address width.
- START_ADDR, 0, PC value loaded while Start is high.
- JOFF_W, 5, width of signed jump offset (Instruction[4:0]).

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  held high by harness to (re)arm; PC parks at START_ADDR.
- Stall  input  1  freeze PC (multi-cycle memory op); highest priority after reset/Start.
- Jump  input  1  from decoder: unconditional PC-relative jump.
- BranchEn  input  1  from decoder: instruction is a conditional branch.
- Taken  input  1  ALU compare result for BEQ/BLT.
- JumpOff  input  JOFF_W  signed offset, Instruction[4:0].
- BrTarget  input  PC_W  absolute target from branch LUT.
- Halt  input  1  decoder OP == oHALT.
- ProgCtr  output  PC_W  current PC to instruction ROM.
- Running  output  1  high in RUN state; gates register/memory writes.
- Done  output  1  high in HALTED state.

Behaviour:
- States (fetch_state_t): IDLE, RUN, HALTED. Reset → IDLE, ProgCtr=START_ADDR, Running=0, Done=0.
- Start=1 in any state: next state IDLE, ProgCtr=START_ADDR. Start has priority over every other input except reset.
- IDLE, Start=0: → RUN next edge; ProgCtr unchanged (first fetch at START_ADDR).
- RUN, one update per rising edge, priority order:
  - Stall=1: hold PC.
  - Halt=1: → HALTED; PC holds, pointing at the halt instruction.
  - Jump=1: PC ← PC + sign_extend(JumpOff).
  - BranchEn=1 and Taken=1: PC ← BrTarget.
  - Otherwise: PC ← PC+1.
- Jump and BranchEn both high: illegal encoding. Jump wins; assertion flags it.
- Arithmetic is modulo 2^PC_W, so wrap-around is silent.
  - PC=1023 +1 → 0.
  - PC=2 + (-4) → 1022.
- HALTED: PC frozen, Done=1, Running=0; leaves only via Start or reset.
- Running/Done are registered state decodes with zero combinational input paths. Latency: next-PC visible one cycle after the instruction is decoded.
- Reset asserted mid-RUN: immediate async return to IDLE/START_ADDR; no partial update.
- Inputs Jump/BranchEn/Halt/Taken are ignored outside RUN.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs CycleCnt[15:0] and TakenCnt[15:0].
  - CycleCnt increments each RUN cycle, including stalls.
  - TakenCnt increments on each applied jump or taken branch.
  - Both clear on reset or Start, freeze in HALTED, and saturate at 16'hFFFF.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package definitions gains:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - PC_W, START_ADDR defaults.
- One combinational sub-module, fetch_next_pc.
  - Inputs: PC, Jump, BranchEn, Taken, JumpOff, BrTarget.
  - Output: next PC, using the priority and wrap rules above.
- fetch_unit keeps the FSM, stall/halt handling and registers.

Test Plan:
- Reset low mid-run at PC=37 → PC=0, Running=0 asynchronously. Reset release + Start pulse → RUN one cycle after Start falls, PC steps 0,1,2.
- RUN at PC=5, Jump=1, JumpOff=5'b11101 (-3) → PC=2 next edge. PC=1023 sequential → PC=0.
- BranchEn=1, Taken=1, BrTarget=300 → PC=300. BranchEn=1, Taken=0 at PC=9 → PC=10.
- Stall=1 for 3 cycles with Jump=1 at PC=12 → PC stays 12. Stall drops with Jump=1, JumpOff=4 → PC=16.
- Halt=1 at PC=50 → Done=1, PC=50 held for 10 cycles despite Jump/BranchEn toggling. Start pulse → IDLE, PC=0, Done=0.
- With FETCH_PERF_CNT_EN: 20 RUN cycles containing 3 taken branches then halt → CycleCnt=20, TakenCnt=3, both frozen afterwards.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the fetch / program-counter stage.
// The FETCH_PERF_CNT_EN build also uses the counter width and saturating increment below.
package fetch_unit_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int START_ADDR_DEF = 0;
    localparam int JOFF_W_DEF     = 5;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump, then taken branch, then sequential step.
// The sum is taken modulo 2^PC_W, so a step or jump past either end wraps silently.
module fetch_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int JOFF_W = JOFF_W_DEF
) (
    input  logic [PC_W-1:0]   pc,
    input  logic              jump,
    input  logic              branch_en,
    input  logic              taken,
    input  logic [JOFF_W-1:0] jump_off,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   next_pc
);

    logic [PC_W-1:0] joff_ext;

    always_comb begin
        joff_ext = {{(PC_W-JOFF_W){jump_off[JOFF_W-1]}}, jump_off};
        next_pc  = pc + PC_W'(1);
        if (jump) begin
            next_pc = pc + joff_ext;
        end else if (branch_en && taken) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and the IDLE/RUN/HALTED sequencing around it.
// Defining FETCH_PERF_CNT_EN adds the CycleCnt/TakenCnt performance counters.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | parked at START_ADDR, waiting for Start to drop
//   RUN    | fetching; PC advances once per edge unless stalled
//   HALTED | halt instruction reached; PC frozen, Done high
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF,
    parameter int JOFF_W     = JOFF_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Jump,
    input  logic              BranchEn,
    input  logic              Taken,
    input  logic [JOFF_W-1:0] JumpOff,
    input  logic [PC_W-1:0]   BrTarget,
    input  logic              Halt,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_W-1:0]  CycleCnt,
    output logic [CNT_W-1:0]  TakenCnt,
`endif
    output logic              Done
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] seq_pc;
    logic            in_run;
    logic            advance;

    fetch_next_pc #(
        .PC_W   (PC_W),
        .JOFF_W (JOFF_W)
    ) u_next_pc (
        .pc        (pc_q),
        .jump      (Jump),
        .branch_en (BranchEn),
        .taken     (Taken),
        .jump_off  (JumpOff),
        .br_target (BrTarget),
        .next_pc   (seq_pc)
    );

    assign in_run  = (state_q == RUN) && !Start;
    assign advance = in_run && !Stall && !Halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (Start) begin
            state_d = IDLE;
            pc_d    = START_PC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (Stall) begin
                        pc_d = pc_q;
                    end else if (Halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = START_PC;
                end
            endcase
        end
        // Status flags are decoded from the next state so the outputs come straight from flops.
        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             redirect;

    assign redirect = advance && (Jump || (BranchEn && Taken));

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (Start) begin
            cycle_cnt_d = '0;
            taken_cnt_d = '0;
        end else begin
            if (in_run) begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
            end
            if (redirect) begin
                taken_cnt_d = sat_inc(taken_cnt_q);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign CycleCnt = cycle_cnt_q;
    assign TakenCnt = taken_cnt_q;
`else
    // Without counters, the advance decode feeds nothing but this tie-off.
    logic unused_advance;
    assign unused_advance = advance;
`endif

    // Jump with BranchEn is an illegal decoder encoding; Jump still wins in the mux.
    illegal_jump_branch: assert property (@(posedge Clk) disable iff (!Reset)
        !(in_run && Jump && BranchEn));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for RUN-state PC updates plus
// hand sequences for halt, restart, asynchronous reset and the optional counters.
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       start, stall, jump, br_en, taken, halt;
    logic [4:0] joff;
    logic [9:0] tgt;
    logic [9:0] pc;
    logic       running, done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt, taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_W       (10),
        .START_ADDR (0),
        .JOFF_W     (5)
    ) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .Start    (start),
        .Stall    (stall),
        .Jump     (jump),
        .BranchEn (br_en),
        .Taken    (taken),
        .JumpOff  (joff),
        .BrTarget (tgt),
        .Halt     (halt),
        .ProgCtr  (pc),
        .Running  (running),
`ifdef FETCH_PERF_CNT_EN
        .CycleCnt (cycle_cnt),
        .TakenCnt (taken_cnt),
`endif
        .Done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, stall, halt, jump, br_en, taken;
        logic [4:0] joff;
        logic [9:0] tgt;
        logic [9:0] exp_pc;
        logic       exp_run, exp_done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic st, input logic h, input logic j,
                         input logic b, input logic t, input logic [4:0] o, input logic [9:0] g);
        start = s; stall = st; halt = h; jump = j; br_en = b; taken = t; joff = o; tgt = g;
    endtask

    task automatic add(input logic s, input logic st, input logic h, input logic j,
                       input logic b, input logic t, input logic [4:0] o, input logic [9:0] g,
                       input logic [9:0] ep, input logic er, input logic ed);
        vec_t v;
        v.start = s; v.stall = st; v.halt = h; v.jump = j; v.br_en = b; v.taken = t;
        v.joff = o; v.tgt = g; v.exp_pc = ep; v.exp_run = er; v.exp_done = ed;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic [9:0] ep, input logic er, input logic ed);
        chk({nm, "_pc"}, 32'(pc), 32'(ep));
        chk({nm, "_running"}, 32'(running), 32'(er));
        chk({nm, "_done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //  start stall halt jump br taken joff     tgt   exp_pc run done
        add(0, 0, 0, 0, 0, 0, 5'd0,     10'd0,   10'd1,    1, 0);
        add(0, 0, 0, 0, 0, 0, 5'd0,     10'd0,   10'd2,    1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd5,   10'd5,    1, 0);
        add(0, 0, 0, 1, 0, 0, 5'b11101, 10'd0,   10'd2,    1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd1023,10'd1023, 1, 0);
        add(0, 0, 0, 0, 0, 0, 5'd0,     10'd0,   10'd0,    1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd300, 10'd300,  1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd9,   10'd9,    1, 0);
        add(0, 0, 0, 0, 1, 0, 5'd0,     10'd500, 10'd10,   1, 0);
        add(0, 0, 0, 0, 0, 1, 5'd0,     10'd700, 10'd11,   1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd2,   10'd2,    1, 0);
        add(0, 0, 0, 1, 0, 0, 5'b11100, 10'd0,   10'd1022, 1, 0);
        add(0, 0, 0, 1, 0, 0, 5'b01111, 10'd0,   10'd13,   1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd12,  10'd12,   1, 0);
        add(0, 1, 0, 1, 0, 0, 5'd4,     10'd0,   10'd12,   1, 0);
        add(0, 1, 0, 1, 0, 0, 5'd4,     10'd0,   10'd12,   1, 0);
        add(0, 1, 0, 1, 0, 0, 5'd4,     10'd0,   10'd12,   1, 0);
        add(0, 0, 0, 1, 0, 0, 5'd4,     10'd0,   10'd16,   1, 0);
        add(0, 1, 1, 0, 0, 0, 5'd0,     10'd0,   10'd16,   1, 0);
        add(1, 1, 0, 1, 0, 0, 5'd4,     10'd0,   10'd0,    0, 0);
        add(0, 0, 0, 0, 0, 0, 5'd0,     10'd0,   10'd0,    1, 0);
        add(0, 0, 0, 0, 0, 0, 5'd0,     10'd0,   10'd1,    1, 0);
        add(0, 0, 0, 0, 1, 1, 5'd0,     10'd50,  10'd50,   1, 0);
        add(0, 0, 1, 1, 0, 0, 5'd3,     10'd0,   10'd50,   0, 1);

        // Reset state, then arm with Start and release it.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        #1;
        chk_state("reset", 10'd0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk_state("start_hi", 10'd0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk_state("first_run", 10'd0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, tbl[i].stall, tbl[i].halt, tbl[i].jump,
                  tbl[i].br_en, tbl[i].taken, tbl[i].joff, tbl[i].tgt);
            tick();
            chk_state($sformatf("row%0d", i), tbl[i].exp_pc, tbl[i].exp_run, tbl[i].exp_done);
        end

        // HALTED ignores jump/branch activity.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, i[0], !i[0], 1, 5'd7, 10'd200);
            tick();
            chk_state($sformatf("halted%0d", i), 10'd50, 0, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk_state("restart_idle", 10'd0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk_state("restart_run", 10'd0, 1, 0);

        // Asynchronous reset in the middle of a cycle at PC=37.
        drive(0, 0, 0, 0, 1, 1, 5'd0, 10'd37);
        tick();
        chk_state("pre_reset", 10'd37, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 10'd0, 0, 0);
        tick();
        chk_state("reset_held", 10'd0, 0, 0);
        #2;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk_state("rearm", 10'd0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk_state("rerun0", 10'd0, 1, 0);
        tick();
        chk_state("rerun1", 10'd1, 1, 0);
        tick();
        chk_state("rerun2", 10'd2, 1, 0);

`ifdef FETCH_PERF_CNT_EN
        // Start clears; 19 non-halt RUN cycles (3 taken, 1 stall, 1 untaken) plus the halt cycle.
        drive(1, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk("cnt_clr_cycle", 32'(cycle_cnt), 32'd0);
        chk("cnt_clr_taken", 32'(taken_cnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk("cnt_idle_cycle", 32'(cycle_cnt), 32'd0);
        for (int i = 0; i < 19; i++) begin
            if (i == 4 || i == 9 || i == 14)
                drive(0, 0, 0, 0, 1, 1, 5'd0, 10'(i * 20));
            else if (i == 6)
                drive(0, 1, 0, 1, 0, 0, 5'd2, 10'd0);
            else if (i == 11)
                drive(0, 0, 0, 0, 1, 0, 5'd0, 10'd100);
            else
                drive(0, 0, 0, 0, 0, 0, 5'd0, 10'd0);
            tick();
        end
        drive(0, 0, 1, 0, 0, 0, 5'd0, 10'd0);
        tick();
        chk("cnt_cycle", 32'(cycle_cnt), 32'd20);
        chk("cnt_taken", 32'(taken_cnt), 32'd3);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0, 0, 5'd1, 10'd0);
            tick();
        end
        chk("cnt_cycle_frozen", 32'(cycle_cnt), 32'd20);
        chk("cnt_taken_frozen", 32'(taken_cnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
